// File: rtl/ula_pkg.sv
// Shared constants and helpers for the 8-bit 74181-style ALU.
// Holds mode constants, function codes, slice width and the X/Y term helpers.
package ula_pkg;

    localparam int SLICE_W = 4;
    localparam int ULA_W   = 2 * SLICE_W;

    localparam logic MODE_LOGIC = 1'b1;
    localparam logic MODE_ARITH = 1'b0;

    // Logic-mode function codes (m = MODE_LOGIC)
    localparam logic [3:0] F_NOT_A   = 4'b0000;
    localparam logic [3:0] F_NOR     = 4'b0001;
    localparam logic [3:0] F_NA_AND_B = 4'b0010;
    localparam logic [3:0] F_ZERO    = 4'b0011;
    localparam logic [3:0] F_NAND    = 4'b0100;
    localparam logic [3:0] F_NOT_B   = 4'b0101;
    localparam logic [3:0] F_XOR     = 4'b0110;
    localparam logic [3:0] F_A_AND_NB = 4'b0111;
    localparam logic [3:0] F_NA_OR_B = 4'b1000;
    localparam logic [3:0] F_XNOR    = 4'b1001;
    localparam logic [3:0] F_PASS_B  = 4'b1010;
    localparam logic [3:0] F_AND     = 4'b1011;
    localparam logic [3:0] F_ONES    = 4'b1100;
    localparam logic [3:0] F_A_OR_NB = 4'b1101;
    localparam logic [3:0] F_OR      = 4'b1110;
    localparam logic [3:0] F_PASS_A  = 4'b1111;

    // Arithmetic-mode function codes (m = MODE_ARITH), before c_in
    localparam logic [3:0] F_A       = 4'b0000;
    localparam logic [3:0] F_MINUS1  = 4'b0011;
    localparam logic [3:0] F_SUB     = 4'b0110;
    localparam logic [3:0] F_ADD     = 4'b1001;
    localparam logic [3:0] F_DOUBLE  = 4'b1100;
    localparam logic [3:0] F_DEC     = 4'b1111;

    // Registered result bundle
    typedef struct packed {
        logic [ULA_W-1:0] f;
        logic             a_eq_b;
        logic             c_out;
    } ula_res_t;

    // X term: A OR-ed with B and/or ~B as selected by s[1:0]
    function automatic logic [SLICE_W-1:0] x_term(
        input logic [SLICE_W-1:0] a,
        input logic [SLICE_W-1:0] b,
        input logic [3:0]         s
    );
        x_term = a
               | (b  & {SLICE_W{s[0]}})
               | (~b & {SLICE_W{s[1]}});
    endfunction

    // Y term: A masked by B and/or ~B as selected by s[3:2]
    function automatic logic [SLICE_W-1:0] y_term(
        input logic [SLICE_W-1:0] a,
        input logic [SLICE_W-1:0] b,
        input logic [3:0]         s
    );
        y_term = (a & b  & {SLICE_W{s[3]}})
               | (a & ~b & {SLICE_W{s[2]}});
    endfunction

endpackage

// File: rtl/ula_4_bits.sv
// Combinational 4-bit ALU slice with the 74181 function set.
// Ports: a, b, s, m, c_in -> f, c_out (0 in logic mode), eq (a == b).
module ula_4_bits
    import ula_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic [3:0]         s,
    input  logic               m,
    input  logic               c_in,
    output logic [SLICE_W-1:0] f,
    output logic               c_out,
    output logic               eq
);

    logic [SLICE_W-1:0] x;
    logic [SLICE_W-1:0] y;
    logic [SLICE_W:0]   sum;

    assign x = x_term(a, b, s);
    assign y = y_term(a, b, s);

    // Carry-out of the slice is bit SLICE_W of the widened sum
    assign sum = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, c_in};

    always_comb begin
        f     = sum[SLICE_W-1:0];
        c_out = sum[SLICE_W];
        if (m == MODE_LOGIC) begin
            f     = ~(x ^ y);
            c_out = 1'b0;
        end
    end

    assign eq = (a == b);

endmodule

// File: rtl/ula_8_bits.sv
// 8-bit 74181-style ALU: two ripple-chained 4-bit slices, registered outputs.
// Ports: clk, rst_n (sync, active-low), a, b, s, m, c_in -> f, a_eq_b, c_out.
module ula_8_bits
    import ula_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ULA_W-1:0] a,
    input  logic [ULA_W-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic [ULA_W-1:0] f,
    output logic             a_eq_b,
    output logic             c_out
);

    logic [SLICE_W-1:0] f_lo;
    logic [SLICE_W-1:0] f_hi;
    logic               c_lo;
    logic               c_hi;
    logic               eq_lo;
    logic               eq_hi;

    ula_res_t res_d;
    ula_res_t res_q;

    ula_4_bits u_lo (
        .a     (a[SLICE_W-1:0]),
        .b     (b[SLICE_W-1:0]),
        .s     (s),
        .m     (m),
        .c_in  (c_in),
        .f     (f_lo),
        .c_out (c_lo),
        .eq    (eq_lo)
    );

    // High slice takes the low slice carry (ripple)
    ula_4_bits u_hi (
        .a     (a[ULA_W-1:SLICE_W]),
        .b     (b[ULA_W-1:SLICE_W]),
        .s     (s),
        .m     (m),
        .c_in  (c_lo),
        .f     (f_hi),
        .c_out (c_hi),
        .eq    (eq_hi)
    );

    always_comb begin
        res_d        = '0;
        res_d.f      = {f_hi, f_lo};
        res_d.a_eq_b = eq_lo & eq_hi;
        res_d.c_out  = c_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign f      = res_q.f;
    assign a_eq_b = res_q.a_eq_b;
    assign c_out  = res_q.c_out;

endmodule

// File: tb/tb_ula_8_bits.sv
// Directed testbench for ula_8_bits.
// Drives vectors, samples 1 time unit after the clock edge.
module tb_ula_8_bits;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [7:0] f;
    logic       a_eq_b;
    logic       c_out;

    int passed = 0;
    int total  = 0;

    ula_8_bits dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .f      (f),
        .a_eq_b (a_eq_b),
        .c_out  (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic apply(input logic [7:0] ta, input logic [7:0] tb,
                         input logic [3:0] ts, input logic tm,
                         input logic tc);
        a    = ta;
        b    = tb;
        s    = ts;
        m    = tm;
        c_in = tc;
        @(posedge clk);
        #1;
    endtask

    task automatic res(input string tag, input logic [7:0] ef,
                       input logic ec, input logic eq);
        chk({tag, ".f"}, f, ef);
        chk({tag, ".c_out"}, {7'b0, c_out}, {7'b0, ec});
        chk({tag, ".eq"}, {7'b0, a_eq_b}, {7'b0, eq});
    endtask

    initial begin
        rst_n = 1'b0;
        apply(8'h12, 8'h12, 4'h9, 1'b0, 1'b1);
        apply(8'hFF, 8'hFF, 4'h9, 1'b0, 1'b1);
        res("reset", 8'h00, 1'b0, 1'b0);

        // Release reset: first result on the next edge
        a = 8'h0F; b = 8'h01; s = 4'h9; m = 1'b0; c_in = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        res("first", 8'h10, 1'b0, 1'b0);

        // Logic mode, a=AA b=55
        apply(8'hAA, 8'h55, 4'h6, 1'b1, 1'b1);
        res("log_xor", 8'hFF, 1'b0, 1'b0);
        apply(8'hAA, 8'h55, 4'hB, 1'b1, 1'b0);
        res("log_and", 8'h00, 1'b0, 1'b0);
        apply(8'hAA, 8'h55, 4'hE, 1'b1, 1'b1);
        res("log_or", 8'hFF, 1'b0, 1'b0);
        apply(8'hAA, 8'h55, 4'h0, 1'b1, 1'b0);
        res("log_nota", 8'h55, 1'b0, 1'b0);
        apply(8'hAA, 8'h55, 4'h3, 1'b1, 1'b1);
        res("log_zero", 8'h00, 1'b0, 1'b0);
        apply(8'hAA, 8'h55, 4'h7, 1'b1, 1'b0);
        res("log_anb", 8'hAA, 1'b0, 1'b0);
        apply(8'hC3, 8'h0F, 4'h1, 1'b1, 1'b0);
        res("log_nor", 8'h30, 1'b0, 1'b0);

        // Add
        apply(8'h0F, 8'h01, 4'h9, 1'b0, 1'b0);
        res("add_nib", 8'h10, 1'b0, 1'b0);
        apply(8'hFF, 8'h01, 4'h9, 1'b0, 1'b0);
        res("add_wrap", 8'h00, 1'b1, 1'b0);
        apply(8'h0F, 8'hF0, 4'h9, 1'b0, 1'b1);
        res("add_cin", 8'h00, 1'b1, 1'b0);
        apply(8'h3C, 8'h25, 4'h9, 1'b0, 1'b0);
        res("add_mid", 8'h61, 1'b0, 1'b0);

        // Subtract
        apply(8'hAA, 8'hAA, 4'h6, 1'b0, 1'b1);
        res("sub_eq", 8'h00, 1'b1, 1'b1);
        apply(8'hAA, 8'hAA, 4'h6, 1'b0, 1'b0);
        res("sub_m1", 8'hFF, 1'b0, 1'b1);
        apply(8'h10, 8'h20, 4'h6, 1'b0, 1'b1);
        res("sub_brw", 8'hF0, 1'b0, 1'b0);

        // Other arithmetic functions
        apply(8'h00, 8'h5A, 4'hF, 1'b0, 1'b0);
        res("dec0", 8'hFF, 1'b0, 1'b0);
        apply(8'h01, 8'h5A, 4'hF, 1'b0, 1'b0);
        res("dec1", 8'h00, 1'b1, 1'b0);
        apply(8'h7F, 8'h00, 4'hC, 1'b0, 1'b0);
        res("dbl", 8'hFE, 1'b0, 1'b0);
        apply(8'h12, 8'h34, 4'h3, 1'b0, 1'b0);
        res("minus1", 8'hFF, 1'b0, 1'b0);
        apply(8'h55, 8'h0F, 4'h0, 1'b0, 1'b0);
        res("pass_a", 8'h55, 1'b0, 1'b0);
        apply(8'hFF, 8'hFF, 4'h9, 1'b0, 1'b1);
        res("add_max", 8'hFF, 1'b1, 1'b1);

        // Equality in both modes
        apply(8'hAA, 8'hAA, 4'h2, 1'b1, 1'b0);
        res("eq_log", 8'h00, 1'b0, 1'b1);
        apply(8'hAA, 8'hAB, 4'h2, 1'b1, 1'b0);
        res("neq_log", 8'h01, 1'b0, 1'b0);
        apply(8'hAA, 8'hAA, 4'h9, 1'b0, 1'b0);
        res("eq_ar", 8'h54, 1'b1, 1'b1);
        apply(8'hAA, 8'hAB, 4'h9, 1'b0, 1'b0);
        res("neq_ar", 8'h55, 1'b1, 1'b0);

        // Mid-stream reset overrides a live operation
        rst_n = 1'b0;
        apply(8'hFF, 8'hFF, 4'h9, 1'b0, 1'b1);
        res("mid_rst", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        apply(8'hFF, 8'hFF, 4'h9, 1'b0, 1'b1);
        res("post_rst", 8'hFF, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
